// File: rtl/fp_subtractor_seq.sv
// Multi-cycle IEEE-754 single-precision subtractor (Diff = A - B) with a start/done handshake.
// Alignment and normalization shift one bit per cycle; round to nearest-even; denormals flush to zero.
module fp_subtractor_seq #(
  parameter int EXP_W     = 8,
  parameter int MAN_W     = 23,
  parameter int ALIGN_MAX = 26
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [EXP_W+MAN_W:0] A,
  input  logic [EXP_W+MAN_W:0] B,
  output logic                 busy,
  output logic                 done,
  output logic [EXP_W+MAN_W:0] Diff,
  output logic                 overflow
);

  localparam int FW = EXP_W + MAN_W + 1;
  localparam int MW = MAN_W + 4;          // hidden, fraction, guard, round, sticky
  localparam int XW = EXP_W + 2;          // headroom for carries past the max exponent
  localparam int CW = $clog2(ALIGN_MAX + 1);
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [FW-1:0]    QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADDSUB, S_NORM, S_ROUND, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [FW-1:0]   a_q, b_q, res_q;
  logic            sign_l, sign_s, ovf_q;
  logic [XW-1:0]   exp_q;
  logic [MW-1:0]   man_l, man_s;
  logic [MW:0]     sum_q;
  logic [CW-1:0]   cnt_q;

  logic             sa, sb, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap, special;
  logic [EXP_W-1:0] ea, eb, ediff;
  logic [CW-1:0]    k;
  logic [MW-1:0]    man_a, man_b, man_s_shr;
  logic [FW-1:0]    spec_res, round_res;
  logic [MW:0]      sum_c, sum_shr;
  logic [XW-1:0]    exp_dec, rexp;
  logic [MAN_W+1:0] rnd;
  logic [MAN_W-1:0] rfrac;
  logic             round_up, round_ovf;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    sa        = a_q[FW-1];
    sb        = ~b_q[FW-1];                 // subtraction is addition of the negated subtrahend
    ea        = a_q[FW-2:MAN_W];
    eb        = b_q[FW-2:MAN_W];
    a_zero    = (ea == '0);
    b_zero    = (eb == '0);
    a_nan     = (ea == EXP_ONES) && (a_q[MAN_W-1:0] != '0);
    b_nan     = (eb == EXP_ONES) && (b_q[MAN_W-1:0] != '0);
    a_inf     = (ea == EXP_ONES) && (a_q[MAN_W-1:0] == '0);
    b_inf     = (eb == EXP_ONES) && (b_q[MAN_W-1:0] == '0);
    man_a     = {1'b1, a_q[MAN_W-1:0], 3'b000};
    man_b     = {1'b1, b_q[MAN_W-1:0], 3'b000};
    swap      = (a_q[FW-2:0] < b_q[FW-2:0]);
    ediff     = swap ? (eb - ea) : (ea - eb);
    k         = (ediff >= EXP_W'(ALIGN_MAX)) ? CW'(ALIGN_MAX) : ediff[CW-1:0];

    special   = 1'b1;
    spec_res  = '0;
    if (a_nan || b_nan)       spec_res = QNAN;
    else if (a_inf && b_inf)  spec_res = (sa == sb) ? a_q : QNAN;
    else if (a_inf)           spec_res = a_q;
    else if (b_inf)           spec_res = {sb, b_q[FW-2:0]};
    else if (a_zero && b_zero) spec_res = {sa & sb, {(FW-1){1'b0}}};
    else if (a_zero)          spec_res = {sb, b_q[FW-2:0]};
    else if (b_zero)          spec_res = a_q;
    else                      special  = 1'b0;

    man_s_shr = {1'b0, man_s[MW-1:2], |man_s[1:0]};
    sum_c     = (sign_l != sign_s) ? ({1'b0, man_l} - {1'b0, man_s})
                                   : ({1'b0, man_l} + {1'b0, man_s});
    sum_shr   = {1'b0, sum_q[MW:2], |sum_q[1:0]};
    exp_dec   = exp_q - 1'b1;

    round_up  = sum_q[2] & (sum_q[1] | sum_q[0] | sum_q[3]);
    rnd       = {1'b0, sum_q[MW-1:3]} + (MAN_W+2)'(round_up);
    rfrac     = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];
    rexp      = exp_q + XW'(rnd[MAN_W+1]);
    round_ovf = 1'b0;
    if (exp_q == '0) begin
      round_res = {sign_l, {(FW-1){1'b0}}};
    end else if (rexp >= XW'(EXP_ONES)) begin
      round_res = {sign_l, EXP_ONES, {MAN_W{1'b0}}};
      round_ovf = 1'b1;
    end else begin
      round_res = {sign_l, rexp[EXP_W-1:0], rfrac};
    end

    case (state_q)
      S_IDLE:   if (start && !busy) state_d = S_UNPACK;
      S_UNPACK: state_d = special ? S_DONE : ((k != '0) ? S_ALIGN : S_ADDSUB);
      S_ALIGN:  if (cnt_q == CW'(1)) state_d = S_ADDSUB;
      S_ADDSUB: begin
        if (sum_c == '0)                     state_d = S_ROUND;
        else if (sum_c[MW] || !sum_c[MW-1])  state_d = S_NORM;
        else                                 state_d = S_ROUND;
      end
      // After this cycle's shift: carry fixed, exponent underflowed, or hidden bit reached.
      S_NORM:   if (sum_q[MW] || exp_dec == '0 || sum_q[MW-2]) state_d = S_ROUND;
      S_ROUND:  state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      sign_l   <= 1'b0;
      sign_s   <= 1'b0;
      exp_q    <= '0;
      man_l    <= '0;
      man_s    <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      Diff     <= '0;
      overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      if (done) busy <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !busy) begin
            a_q      <= A;
            b_q      <= B;
            busy     <= 1'b1;
            overflow <= 1'b0;
          end
        end
        S_UNPACK: begin
          res_q  <= spec_res;
          ovf_q  <= 1'b0;
          sign_l <= swap ? sb : sa;
          sign_s <= swap ? sa : sb;
          exp_q  <= XW'(swap ? eb : ea);
          man_l  <= swap ? man_b : man_a;
          man_s  <= swap ? man_a : man_b;
          cnt_q  <= k;
        end
        S_ALIGN: begin
          man_s <= man_s_shr;
          cnt_q <= cnt_q - 1'b1;
        end
        S_ADDSUB: begin
          sum_q <= sum_c;
          if (sum_c == '0) begin
            sign_l <= 1'b0;
            exp_q  <= '0;
          end
        end
        S_NORM: begin
          if (sum_q[MW]) begin
            sum_q <= sum_shr;
            exp_q <= exp_q + 1'b1;
          end else if (exp_dec == '0) begin
            sum_q <= '0;
            exp_q <= '0;
          end else begin
            sum_q <= {sum_q[MW-1:0], 1'b0};
            exp_q <= exp_dec;
          end
        end
        S_ROUND: begin
          res_q <= round_res;
          ovf_q <= round_ovf;
        end
        S_DONE: begin
          done     <= 1'b1;
          Diff     <= res_q;
          overflow <= ovf_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_subtractor_seq.sv
// Bench for fp_subtractor_seq: exact big-integer reference model, per-cycle compare process,
// and hand-computed literal vectors that pin the model.
module tb_fp_subtractor_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, overflow;
  logic [31:0] diff;

  fp_subtractor_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(a), .B(b),
    .busy(busy), .done(done), .Diff(diff), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  // Exact value arithmetic: operands become signed integers on a common scale, the
  // difference is rounded to 24 significant bits (nearest-even), then re-encoded.
  function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic ovf, output int lat);
    logic sx, sy, sgn, xnan, ynan, xinf, yinf, xz, yz;
    int ex, ey, emin, el, p, e, sh, k, n;
    logic signed [299:0] vx, vy, v;
    logic [299:0] mag, keep, rem, half;
    sx = x[31]; sy = ~y[31];
    ex = int'(x[30:23]); ey = int'(y[30:23]);
    xnan = (ex == 255) && (x[22:0] != 0); ynan = (ey == 255) && (y[22:0] != 0);
    xinf = (ex == 255) && (x[22:0] == 0); yinf = (ey == 255) && (y[22:0] == 0);
    xz = (ex == 0); yz = (ey == 0);
    ovf = 1'b0; lat = 2; r = '0;
    if (xnan || ynan)      r = 32'h7FC00000;
    else if (xinf && yinf) r = (sx == sy) ? x : 32'h7FC00000;
    else if (xinf)         r = x;
    else if (yinf)         r = {sy, y[30:0]};
    else if (xz && yz)     r = {sx & sy, 31'b0};
    else if (xz)           r = {sy, y[30:0]};
    else if (yz)           r = x;
    else begin
      emin = (ex < ey) ? ex : ey;
      el   = (ex > ey) ? ex : ey;
      k    = (ex > ey) ? ex - ey : ey - ex;
      if (k > 26) k = 26;
      vx = 300'({1'b1, x[22:0]}) << (ex - emin);
      vy = 300'({1'b1, y[22:0]}) << (ey - emin);
      if (sx) vx = -vx;
      if (sy) vy = -vy;
      v = vx + vy;
      if (v == 0) begin
        r = 32'h0; lat = 4 + k;
      end else begin
        sgn = (v < 0);
        mag = sgn ? 300'(-v) : 300'(v);
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        e = p + emin - 23;               // biased exponent before rounding
        if (e > el)     n = 1;
        else if (e < 1) n = el;
        else            n = el - e;
        lat = 4 + k + n;
        if (e < 1) begin
          r = {sgn, 31'b0};
        end else begin
          if (p > 23) begin
            sh   = p - 23;
            keep = mag >> sh;
            rem  = mag & ((300'd1 << sh) - 300'd1);
            half = 300'd1 << (sh - 1);
            if (rem > half || (rem == half && keep[0])) keep = keep + 300'd1;
          end else begin
            keep = mag << (23 - p);
          end
          if (keep == (300'd1 << 24)) begin
            keep = keep >> 1; e = e + 1;
          end
          if (e >= 255) begin
            r = {sgn, 8'hFF, 23'b0}; ovf = 1'b1;
          end else begin
            r = {sgn, e[7:0], keep[22:0]};
          end
        end
      end
    end
  endfunction

  // Expectations shared between the driver and the compare process.
  logic        pending   = 1'b0;
  int          cyc       = 0;
  int          exp_lat   = 0;
  logic [31:0] exp_diff  = '0;
  logic        exp_ovf   = 1'b0;
  logic [31:0] held_diff = '0;
  logic        held_ovf  = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_diff", diff, 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      pending   = 1'b0;
      held_diff = '0;
      held_ovf  = 1'b0;
    end else if (pending) begin
      check("done_timing", 32'(done), 32'(cyc == exp_lat));
      check("busy_running", 32'(busy), 32'd1);
      if (done) begin
        check("diff", diff, exp_diff);
        check("overflow", 32'(overflow), 32'(exp_ovf));
        held_diff = exp_diff;
        held_ovf  = exp_ovf;
        pending   = 1'b0;
      end else begin
        check("diff_hold", diff, held_diff);
        check("ovf_cleared", 32'(overflow), 32'd0);
      end
      cyc++;
      if (pending && cyc > exp_lat + 3) begin
        n_checks++;
        $display("FAIL done_timeout: no done after %0d cycles, required at %0d", cyc, exp_lat);
        pending = 1'b0;
      end
    end else begin
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      check("idle_diff", diff, held_diff);
      check("idle_ovf", 32'(overflow), 32'(held_ovf));
    end
  end

  task automatic launch(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r; logic o; int l;
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    model(x, y, r, o, l);
    exp_diff = r; exp_ovf = o; exp_lat = l; cyc = 0; pending = 1'b1;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200 && pending; i++) @(posedge clk);
    if (pending) begin
      n_checks++;
      $display("FAIL wait_done: operation still pending after 200 cycles");
      pending = 1'b0;
    end
  endtask

  task automatic run(input logic [31:0] x, input logic [31:0] y, input bit poke);
    launch(x, y);
    if (poke) begin
      repeat (2) @(negedge clk);
      a = 32'h40000000; b = 32'hC0000000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done();
  endtask

  task automatic pin(input string name, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] lit, input logic lit_ovf, input int lit_lat);
    logic [31:0] r; logic o; int l;
    model(x, y, r, o, l);
    check({name, "_model"}, r, lit);
    check({name, "_model_lat"}, 32'(l), 32'(lit_lat));
    run(x, y, 1'b0);
    check(name, diff, lit);
    check({name, "_ovf"}, 32'(overflow), 32'(lit_ovf));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    pin("one_minus_half",   32'h3F800000, 32'h3F000000, 32'h3F000000, 1'b0, 6);
    pin("quarter_plus_8th", 32'h3E800000, 32'hBE000000, 32'h3EC00000, 1'b0, 5);
    pin("one_plus_half",    32'h3F800000, 32'hBF000000, 32'h3FC00000, 1'b0, 5);
    pin("x_minus_x",        32'h40400000, 32'h40400000, 32'h00000000, 1'b0, 4);
    pin("inf_minus_inf",    32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b0, 2);
    pin("max_overflow",     32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 1'b1, 5);
    pin("one_minus_2m24",   32'h3F800000, 32'h33800000, 32'h3F7FFFFF, 1'b0, 29);
    pin("tie_even_up",      32'h3F800000, 32'h33000000, 32'h3F800000, 1'b0, 30);
    pin("tie_even_down",    32'h3F800001, 32'h33800000, 32'h3F800000, 1'b0, 28);
    pin("align_max",        32'h4C800000, 32'h3F800000, 32'h4C800000, 1'b0, 31);
    pin("align_beyond",     32'h4F800000, 32'h3F800000, 32'h4F800000, 1'b0, 31);
    pin("long_norm",        32'h3F800001, 32'h3F800000, 32'h34000000, 1'b0, 27);
    pin("flush_neg_zero",   32'h00800000, 32'h00800001, 32'h80000000, 1'b0, 5);
    pin("flush_pos_zero",   32'h01000001, 32'h01000000, 32'h00000000, 1'b0, 6);
    pin("zero_minus_y",     32'h00000000, 32'h40490FDB, 32'hC0490FDB, 1'b0, 2);
    pin("x_minus_zero",     32'h40490FDB, 32'h80000000, 32'h40490FDB, 1'b0, 2);
    pin("negz_minus_posz",  32'h80000000, 32'h00000000, 32'h80000000, 1'b0, 2);
    pin("negz_minus_negz",  32'h80000000, 32'h80000000, 32'h00000000, 1'b0, 2);
    pin("nan_operand",      32'h7F800001, 32'h3F800000, 32'h7FC00000, 1'b0, 2);
    pin("neg_inf_minus_x",  32'hFF800000, 32'h3F800000, 32'hFF800000, 1'b0, 2);
    pin("x_minus_inf",      32'h3F800000, 32'h7F800000, 32'hFF800000, 1'b0, 2);
    pin("denorm_minus_one", 32'h00400000, 32'h3F800000, 32'hBF800000, 1'b0, 2);

    // Extra operands without literals; the model alone supplies the expectations.
    run(32'h42F6E979, 32'h3E4CCCCD, 1'b0);
    run(32'hC1200000, 32'h41A00000, 1'b0);
    run(32'h3DCCCCCD, 32'h3E4CCCCD, 1'b0);

    // start while busy is ignored; the original operands' result must come back.
    run(32'h3F800000, 32'h33800000, 1'b1);
    check("poke_result", diff, 32'h3F7FFFFF);
    repeat (5) @(negedge clk);

    // Reset in the middle of alignment abandons the operation immediately.
    launch(32'h3F800000, 32'h33800000);
    repeat (3) @(posedge clk);
    #2;
    rst_n   = 1'b0;
    pending = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_diff", diff, 32'd0);
    check("midrst_ovf", 32'(overflow), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    pin("after_reset", 32'h3F800000, 32'h3F000000, 32'h3F000000, 1'b0, 6);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
